hazard_scheduler: RTL and testbench

- Pipeline sequencing controller for the 5-stage core; it sits beside the decode stage.
- Keeps a 3-entry scoreboard of in-flight destinations for the EXE, MEM and WB stages.
- From the scoreboard it decides per cycle: stall/bubble on data hazards, flush on taken branches, whole-pipe freeze on memory wait.
- Produces operand-forwarding selects for the EXE-stage ALU inputs and keeps a saturating stall-cycle counter.

---
 rtl/hazard_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_hazard_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// ---------------------------------------------------------------------------
// hazard_scheduler
//
// Pipeline sequencing controller for the 5-stage core, sitting beside the
// decode stage. It tracks the instructions currently in EXE, MEM and WB in
// a small scoreboard. From that scoreboard it decides each cycle whether
// decode must stall on a data hazard, whether IF/ID must be flushed after a
// taken branch, and whether the whole pipe freezes while data memory is
// busy. It also drives the ALU operand-forwarding selects for the EXE stage
// and keeps a saturating count of hazard-stall cycles.
//
// Parameters:
//   FORWARD_EN  1 = forwarding active, stall only on load-use
//               0 = no forwarding, stall on any RAW match in EXE or MEM
//   REG_BITS    register index width
//   CNT_W       stall counter width
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   id_src1       decode rs
//   id_src2       decode rt
//   id_two_src    decode instruction reads rt as a register
//   id_wb_en      decode instruction writes back
//   id_dest       decode destination index
//   id_mem_read   decode instruction is a load
//   exe_br_taken  branch resolved taken in EXE this cycle
//   mem_ready     0 = data memory busy, freeze the pipe
//   freeze_front  hold PC and IF/ID register
//   bubble_idexe  load NOP control into ID/EXE
//   flush_ifid    clear IF/ID register
//   freeze_back   hold ID/EXE, EXE/MEM, MEM/WB registers
//   fwd_sel_a     ALU input A select: 00 regfile, 01 EXE/MEM, 10 MEM/WB
//   fwd_sel_b     ALU input B / store data select, same encoding
//   stall_count   saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module hazard_scheduler #(
    parameter int FORWARD_EN = 1,
    parameter int REG_BITS   = 5,
    parameter int CNT_W      = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_src1,
    input  logic [REG_BITS-1:0] id_src2,
    input  logic                id_two_src,
    input  logic                id_wb_en,
    input  logic [REG_BITS-1:0] id_dest,
    input  logic                id_mem_read,
    input  logic                exe_br_taken,
    input  logic                mem_ready,
    output logic                freeze_front,
    output logic                bubble_idexe,
    output logic                flush_ifid,
    output logic                freeze_back,
    output logic [1:0]          fwd_sel_a,
    output logic [1:0]          fwd_sel_b,
    output logic [CNT_W-1:0]    stall_count
);

    typedef logic [REG_BITS-1:0] reg_idx_t;

    // EXE needs its source operands for forwarding; the later stages only
    // need what is required to describe the value they will write back.
    typedef struct packed {
        logic     valid;
        logic     wb_en;
        logic     is_load;
        reg_idx_t dest;
        reg_idx_t src1;
        reg_idx_t src2;
        logic     two_src;
    } exe_entry_t;

    typedef struct packed {
        logic     valid;
        logic     wb_en;
        logic     is_load;
        reg_idx_t dest;
    } mem_entry_t;

    typedef struct packed {
        logic     valid;
        logic     wb_en;
        reg_idx_t dest;
    } wb_entry_t;

    exe_entry_t       exe_q, exe_d;
    mem_entry_t       mem_q, mem_d;
    wb_entry_t        wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       src1_hazard;
    logic       src2_hazard;
    logic       hazard;
    logic       stall_inc;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // Register 0 is hardwired, so a write to it never produces a value
    // anybody has to wait for or forward.
    function automatic logic writes_reg(input logic     valid,
                                        input logic     wb_en,
                                        input reg_idx_t dest,
                                        input reg_idx_t r);
        return valid && wb_en && (dest == r) && (r != '0);
    endfunction

    // A load in MEM has no data yet on the EXE/MEM path, so it can only be
    // forwarded from MEM/WB one cycle later.
    function automatic logic [1:0] fwd_select(input mem_entry_t m,
                                              input wb_entry_t  w,
                                              input reg_idx_t   r);
        logic [1:0] sel;
        sel = 2'b00;
        if (writes_reg(m.valid, m.wb_en, m.dest, r) && !m.is_load) begin
            sel = 2'b01;
        end else if (writes_reg(w.valid, w.wb_en, w.dest, r)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Hazard detection against the decode sources. With forwarding only a
    // load in EXE is too late to forward; without forwarding anything still
    // in EXE or MEM must drain. WB matches are resolved by the register file
    // writing in the first half of the cycle.
    always_comb begin
        src1_hazard = 1'b0;
        src2_hazard = 1'b0;
        if (FORWARD_EN != 0) begin
            src1_hazard = writes_reg(exe_q.valid, exe_q.wb_en, exe_q.dest, id_src1)
                          && exe_q.is_load;
            src2_hazard = writes_reg(exe_q.valid, exe_q.wb_en, exe_q.dest, id_src2)
                          && exe_q.is_load;
        end else begin
            src1_hazard = writes_reg(exe_q.valid, exe_q.wb_en, exe_q.dest, id_src1)
                          || writes_reg(mem_q.valid, mem_q.wb_en, mem_q.dest, id_src1);
            src2_hazard = writes_reg(exe_q.valid, exe_q.wb_en, exe_q.dest, id_src2)
                          || writes_reg(mem_q.valid, mem_q.wb_en, mem_q.dest, id_src2);
        end
        hazard = src1_hazard || (id_two_src && src2_hazard);
    end

    // Control priority: memory wait freezes everything, a taken branch
    // discards the decode instruction (so its hazard no longer matters),
    // and only then does a data hazard stall the front end.
    always_comb begin
        freeze_front = 1'b0;
        bubble_idexe = 1'b0;
        flush_ifid   = 1'b0;
        freeze_back  = 1'b0;
        stall_inc    = 1'b0;
        if (reset) begin
            freeze_front = 1'b0;
        end else if (!mem_ready) begin
            freeze_front = 1'b1;
            freeze_back  = 1'b1;
        end else if (exe_br_taken) begin
            flush_ifid   = 1'b1;
            bubble_idexe = 1'b1;
        end else if (hazard) begin
            freeze_front = 1'b1;
            bubble_idexe = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    // Scoreboard advances in lockstep with the pipeline registers, which
    // only move while memory is ready.
    always_comb begin
        exe_d       = exe_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (mem_ready) begin
            wb_d  = '{valid: mem_q.valid, wb_en: mem_q.wb_en, dest: mem_q.dest};
            mem_d = '{valid: exe_q.valid, wb_en: exe_q.wb_en,
                      is_load: exe_q.is_load, dest: exe_q.dest};
            if (bubble_idexe) begin
                exe_d = '0;
            end else begin
                exe_d = '{valid: 1'b1, wb_en: id_wb_en, is_load: id_mem_read,
                          dest: id_dest, src1: id_src1, src2: id_src2,
                          two_src: id_two_src};
            end
        end
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset empties the scoreboard immediately so the
    // first instruction after release sees no producers in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forwarding selects for the instruction currently in EXE. Operand B
    // only matters when that instruction actually reads rt as a register.
    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (exe_q.valid) begin
            fwd_a_raw = fwd_select(mem_q, wb_q, exe_q.src1);
            if (exe_q.two_src) begin
                fwd_b_raw = fwd_select(mem_q, wb_q, exe_q.src2);
            end
        end
    end

    assign fwd_sel_a   = ((FORWARD_EN != 0) && !reset) ? fwd_a_raw : 2'b00;
    assign fwd_sel_b   = ((FORWARD_EN != 0) && !reset) ? fwd_b_raw : 2'b00;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hazard_scheduler
//
// Drives two hazard_scheduler instances from one decode stream: one with
// forwarding and a 16-bit counter, one without forwarding and a 4-bit
// counter so saturation is reachable quickly. A behavioural model of the
// three in-flight instructions per instance predicts every output on each
// falling edge; directed sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_hazard_scheduler;

    logic        clock;
    logic        reset;
    logic [4:0]  idSrc1;
    logic [4:0]  idSrc2;
    logic        idTwoSrc;
    logic        idWbEn;
    logic [4:0]  idDest;
    logic        idMemRead;
    logic        exeBrTaken;
    logic        memReady;

    logic        ff1, bub1, fl1, fb1;
    logic [1:0]  fa1, fbs1;
    logic [15:0] cnt1;
    logic        ff0, bub0, fl0, fb0;
    logic [1:0]  fa0, fbs0;
    logic [3:0]  cnt0;

    int checks = 0;
    int errors = 0;

    hazard_scheduler #(.FORWARD_EN(1), .REG_BITS(5), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset),
        .id_src1(idSrc1), .id_src2(idSrc2), .id_two_src(idTwoSrc),
        .id_wb_en(idWbEn), .id_dest(idDest), .id_mem_read(idMemRead),
        .exe_br_taken(exeBrTaken), .mem_ready(memReady),
        .freeze_front(ff1), .bubble_idexe(bub1), .flush_ifid(fl1),
        .freeze_back(fb1), .fwd_sel_a(fa1), .fwd_sel_b(fbs1),
        .stall_count(cnt1)
    );

    hazard_scheduler #(.FORWARD_EN(0), .REG_BITS(5), .CNT_W(4)) dut0 (
        .clock(clock), .reset(reset),
        .id_src1(idSrc1), .id_src2(idSrc2), .id_two_src(idTwoSrc),
        .id_wb_en(idWbEn), .id_dest(idDest), .id_mem_read(idMemRead),
        .exe_br_taken(exeBrTaken), .mem_ready(memReady),
        .freeze_front(ff0), .bubble_idexe(bub0), .flush_ifid(fl0),
        .freeze_back(fb0), .fwd_sel_a(fa0), .fwd_sel_b(fbs0),
        .stall_count(cnt0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wb;
        logic       ld;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       two;
    } ent_t;

    // index 0 = EXE, 1 = MEM, 2 = WB
    ent_t pipe1 [3];
    ent_t pipe0 [3];
    int   modelCnt1;
    int   modelCnt0;
    ent_t decodeEnt;

    assign decodeEnt = {1'b1, idDest, idWbEn, idMemRead, idSrc1, idSrc2, idTwoSrc};

    function automatic bit produces(ent_t e, logic [4:0] r);
        return e.valid && e.wb && (e.dest == r) && (r != 5'd0);
    endfunction

    function automatic bit mustWait(bit fe, ent_t ex, ent_t me, logic [4:0] r);
        if (fe) return produces(ex, r) && ex.ld;
        return produces(ex, r) || produces(me, r);
    endfunction

    function automatic bit isHazard(bit fe, ent_t ex, ent_t me);
        return mustWait(fe, ex, me, idSrc1) || (idTwoSrc && mustWait(fe, ex, me, idSrc2));
    endfunction

    // {freeze_front, bubble_idexe, flush_ifid, freeze_back}
    function automatic logic [3:0] expCtrl(bit fe, ent_t ex, ent_t me);
        if (reset) return 4'b0000;
        if (!memReady) return 4'b1001;
        if (exeBrTaken) return 4'b0110;
        if (isHazard(fe, ex, me)) return 4'b1100;
        return 4'b0000;
    endfunction

    function automatic logic [1:0] srcSel(ent_t me, ent_t wb, logic [4:0] r);
        if (produces(me, r) && !me.ld) return 2'b01;
        if (produces(wb, r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] expFwd(bit fe, ent_t ex, ent_t me, ent_t wb);
        logic [1:0] a;
        logic [1:0] b;
        a = 2'b00;
        b = 2'b00;
        if (!reset && fe && ex.valid) begin
            a = srcSel(me, wb, ex.s1);
            if (ex.two) b = srcSel(me, wb, ex.s2);
        end
        return {a, b};
    endfunction

    // The model advances its in-flight list whenever memory is ready; a
    // discarded or stalled decode slot enters EXE as an empty entry.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pipe1[i] <= '0;
                pipe0[i] <= '0;
            end
            modelCnt1 <= 0;
            modelCnt0 <= 0;
        end else if (memReady) begin
            pipe1[2] <= pipe1[1];
            pipe1[1] <= pipe1[0];
            pipe1[0] <= (exeBrTaken || isHazard(1'b1, pipe1[0], pipe1[1])) ? '0 : decodeEnt;
            pipe0[2] <= pipe0[1];
            pipe0[1] <= pipe0[0];
            pipe0[0] <= (exeBrTaken || isHazard(1'b0, pipe0[0], pipe0[1])) ? '0 : decodeEnt;
            if (!exeBrTaken && isHazard(1'b1, pipe1[0], pipe1[1]) && modelCnt1 < 65535)
                modelCnt1 <= modelCnt1 + 1;
            if (!exeBrTaken && isHazard(1'b0, pipe0[0], pipe0[1]) && modelCnt0 < 15)
                modelCnt0 <= modelCnt0 + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clock) begin
        checkOutput("ctrl1", {28'd0, ff1, bub1, fl1, fb1}, {28'd0, expCtrl(1'b1, pipe1[0], pipe1[1])});
        checkOutput("fwd1", {28'd0, fa1, fbs1}, {28'd0, expFwd(1'b1, pipe1[0], pipe1[1], pipe1[2])});
        checkOutput("cnt1", {16'd0, cnt1}, modelCnt1);
        checkOutput("ctrl0", {28'd0, ff0, bub0, fl0, fb0}, {28'd0, expCtrl(1'b0, pipe0[0], pipe0[1])});
        checkOutput("fwd0", {28'd0, fa0, fbs0}, {28'd0, expFwd(1'b0, pipe0[0], pipe0[1], pipe0[2])});
        checkOutput("cnt0", {28'd0, cnt0}, modelCnt0);
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                                 input logic wb, input logic [4:0] d, input logic ld,
                                 input logic br, input logic mr);
        @(posedge clock);
        #2;
        idSrc1     = s1;
        idSrc2     = s2;
        idTwoSrc   = two;
        idWbEn     = wb;
        idDest     = d;
        idMemRead  = ld;
        exeBrTaken = br;
        memReady   = mr;
        @(negedge clock);
    endtask

    task automatic applyReset(input logic r);
        @(posedge clock);
        #2;
        reset = r;
        @(negedge clock);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset      = 1'b1;
        idSrc1     = '0;
        idSrc2     = '0;
        idTwoSrc   = 1'b0;
        idWbEn     = 1'b0;
        idDest     = '0;
        idMemRead  = 1'b0;
        exeBrTaken = 1'b0;
        memReady   = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("rst_ctrl1", {ff1, bub1, fl1, fb1, fa1, fbs1}, 0);
        checkOutput("rst_cnt1", cnt1, 0);
        applyReset(1'b0);

        // load-use with forwarding: exactly one stall, then MEM/WB forward
        applyStimulus(0, 0, 0, 1, 3, 1, 0, 1);
        applyStimulus(3, 5, 1, 1, 4, 0, 0, 1);
        checkOutput("lu_stall", {ff1, bub1}, 2'b11);
        applyStimulus(3, 5, 1, 1, 4, 0, 0, 1);
        checkOutput("lu_release", ff1, 0);
        checkOutput("lu_cnt", cnt1, 1);
        nop(1);
        checkOutput("lu_fwd", {fa1, fbs1}, 4'b1000);
        nop(3);

        // ALU back-to-back, then with one independent instruction between
        applyStimulus(0, 0, 1, 1, 2, 0, 0, 1);
        applyStimulus(2, 2, 1, 1, 6, 0, 0, 1);
        checkOutput("b2b_nostall", ff1, 0);
        nop(1);
        checkOutput("b2b_fwd", {fa1, fbs1}, 4'b0101);
        nop(3);
        applyStimulus(0, 0, 1, 1, 2, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 9, 0, 0, 1);
        applyStimulus(2, 2, 1, 1, 6, 0, 0, 1);
        nop(1);
        checkOutput("gap_fwd", {fa1, fbs1}, 4'b1010);
        nop(3);

        // register 0 and single-source immunity
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 4, 0, 0, 1);
        checkOutput("r0_nostall", {ff1, ff0}, 2'b00);
        applyStimulus(0, 0, 0, 1, 7, 1, 0, 1);
        applyStimulus(1, 7, 0, 1, 8, 0, 0, 1);
        checkOutput("onesrc_nostall", ff1, 0);
        nop(3);

        // taken branch masks a load-use hazard
        applyStimulus(0, 0, 0, 1, 3, 1, 0, 1);
        applyStimulus(3, 5, 1, 1, 4, 0, 1, 1);
        checkOutput("br_ctrl", {ff1, bub1, fl1, fb1}, 4'b0110);
        nop(1);
        checkOutput("br_cnt", cnt1, 1);
        nop(3);

        // memory wait over a load-use hazard
        applyStimulus(0, 0, 0, 1, 3, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3, 5, 1, 1, 4, 0, 0, 0);
            checkOutput("mw_freeze", {ff1, bub1, fl1, fb1}, 4'b1001);
        end
        applyStimulus(3, 5, 1, 1, 4, 0, 0, 1);
        checkOutput("mw_stall", {ff1, bub1, fb1}, 3'b110);
        applyStimulus(3, 5, 1, 1, 4, 0, 0, 1);
        checkOutput("mw_release", ff1, 0);
        checkOutput("mw_cnt", cnt1, 2);
        nop(3);

        // no forwarding: two stall cycles on an ALU dependency
        applyReset(1'b1);
        applyReset(1'b0);
        applyStimulus(0, 0, 1, 1, 2, 0, 0, 1);
        applyStimulus(2, 0, 0, 1, 8, 0, 0, 1);
        checkOutput("nf_stall1", ff0, 1);
        applyStimulus(2, 0, 0, 1, 8, 0, 0, 1);
        checkOutput("nf_stall2", ff0, 1);
        applyStimulus(2, 0, 0, 1, 8, 0, 0, 1);
        checkOutput("nf_issue", ff0, 0);
        checkOutput("nf_cnt", cnt0, 2);
        nop(1);
        checkOutput("nf_fwd", {fa0, fbs0}, 4'b0000);
        nop(3);

        // reset in the middle of a stall
        applyStimulus(0, 0, 1, 1, 2, 0, 0, 1);
        applyStimulus(2, 0, 0, 1, 8, 0, 0, 1);
        applyReset(1'b1);
        checkOutput("rst_mid_ctrl", {ff0, bub0, fl0, fb0}, 4'b0000);
        checkOutput("rst_mid_cnt", cnt0, 0);
        applyReset(1'b0);
        checkOutput("rst_release", ff0, 0);

        // saturate the narrow counter
        for (int i = 0; i < 30; i++) applyStimulus(2, 0, 0, 1, 2, 0, 0, 1);
        checkOutput("sat_cnt0", cnt0, 4'hF);
        checkOutput("sat_cnt1", cnt1, 0);
        nop(3);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] rs1, rs2, rd;
            logic       rtwo, rwb, rld, rbr, rmr;
            if ($urandom_range(0, 99) == 0) begin
                applyReset(1'b1);
                applyReset(1'b0);
            end else begin
                rs1  = 5'($urandom_range(0, 7));
                rs2  = 5'($urandom_range(0, 7));
                rd   = 5'($urandom_range(0, 7));
                rtwo = 1'($urandom_range(0, 1));
                rwb  = ($urandom_range(0, 3) != 0);
                rld  = ($urandom_range(0, 2) == 0);
                rbr  = ($urandom_range(0, 9) == 0);
                rmr  = ($urandom_range(0, 4) != 0);
                applyStimulus(rs1, rs2, rtwo, rwb, rd, rld, rbr, rmr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
